// File: rtl/shift_register_pkg.sv
// Shared constants for the circular rotate-right shift register.
package shift_register_pkg;

  // Nominal register width; the block is built and verified at this size.
  localparam int SR_WIDTH = 5;

  // Value every bit takes while clear is asserted.
  localparam logic [SR_WIDTH-1:0] SR_RESET_VAL = '0;

endpackage : shift_register_pkg

// File: rtl/dff_async_clr.sv
// Single-bit D flip-flop with asynchronous active-low clear.
// RST_VAL selects the value forced while clr_n is low.
module dff_async_clr #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  // Clear takes effect immediately; otherwise capture d on the rising edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule : dff_async_clr

// File: rtl/shift_register_circular_right5.sv
// Parallel-load circular rotate-right shift register with true and
// complemented outputs. Built from one async-clear flop per bit, each fed by
// its own next-state mux (preset bit / hold / left-hand neighbour).
//
// Optional build macro SR_HOLD_EN adds a 'hold' input that freezes the
// register on edges where no load is requested.
// Priority: clear > preset_enable > hold > rotate.
module shift_register_circular_right5
  import shift_register_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             preset_enable,
  input  logic [WIDTH-1:0] preset,
`ifdef SR_HOLD_EN
  input  logic             hold,
`endif
  output logic [WIDTH-1:0] signal_q,
  output logic [WIDTH-1:0] signal_q_
);

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(SR_RESET_VAL);

  logic [WIDTH-1:0] sig_q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      // Rotating right: each bit takes its upper neighbour, the MSB wraps
      // around from bit 0.
      localparam int SRC = (gi == WIDTH - 1) ? 0 : gi + 1;

      logic bit_d;

      // Per-bit next-state select; preset only reaches the flop on a load,
      // so an unknown preset cannot leak into a rotate.
      always_comb begin
        bit_d = sig_q[SRC];
        if (preset_enable) begin
          bit_d = preset[gi];
        end
`ifdef SR_HOLD_EN
        else if (hold) begin
          bit_d = sig_q[gi];
        end
`endif
      end

      dff_async_clr #(
        .RST_VAL (RESET_VAL[gi])
      ) u_dff (
        .clk   (clockpulse),
        .clr_n (clear),
        .d     (bit_d),
        .q     (sig_q[gi])
      );
    end
  endgenerate

  assign signal_q  = sig_q;
  // Complement follows the register combinationally, reset included.
  assign signal_q_ = ~sig_q;

endmodule : shift_register_circular_right5

// File: tb/tb_shift_register_circular_right5.sv
// Scoreboard bench for shift_register_circular_right5. Expected register
// values are pushed when stimulus is applied and popped after the edge.
// Hold-related stimulus is only applied when SR_HOLD_EN is defined.
module tb_shift_register_circular_right5;
  import shift_register_pkg::*;

  localparam int W = SR_WIDTH;
`ifdef SR_HOLD_EN
  localparam bit HOLD_BUILT = 1'b1;
`else
  localparam bit HOLD_BUILT = 1'b0;
`endif

  logic         clockpulse = 1'b0;
  logic         clear;
  logic         preset_enable;
  logic [W-1:0] preset;
  logic [W-1:0] signal_q;
  logic [W-1:0] signal_q_;
`ifdef SR_HOLD_EN
  logic         hold;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] model_q;
  logic [W-1:0] exp_q[$];

  shift_register_circular_right5 #(.WIDTH(W)) dut (
    .clockpulse    (clockpulse),
    .clear         (clear),
    .preset_enable (preset_enable),
    .preset        (preset),
`ifdef SR_HOLD_EN
    .hold          (hold),
`endif
    .signal_q      (signal_q),
    .signal_q_     (signal_q_)
  );

  always #5 clockpulse = ~clockpulse;

  task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end else begin
      $display("ok   %s: %b", tag, act);
    end
  endtask

  // Both outputs against an expected register value.
  task automatic check_both(input string tag, input logic [W-1:0] exp);
    check_val(tag, signal_q, exp);
    check_val({tag, "_n"}, signal_q_, ~exp);
  endtask

  // Drive one edge worth of stimulus, predict, wait for the edge, compare.
  task automatic step(input string tag, input logic pe, input logic [W-1:0] pv, input logic hd);
    logic [W-1:0] exp;
    preset_enable = pe;
    preset        = pv;
`ifdef SR_HOLD_EN
    hold          = hd;
`endif
    if (!clear)                 model_q = '0;
    else if (pe)                model_q = pv;
    else if (hd && HOLD_BUILT)  model_q = model_q;
    else                        model_q = {model_q[0], model_q[W-1:1]};
    exp_q.push_back(model_q);
    @(posedge clockpulse);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty, got %b expected an entry", tag, signal_q);
    end else begin
      exp = exp_q.pop_front();
      check_both(tag, exp);
    end
  endtask

  initial begin
    clear         = 1'b0;
    preset_enable = 1'b1;
    preset        = 5'b11000;
`ifdef SR_HOLD_EN
    hold          = 1'b0;
`endif
    model_q       = '0;

    // Reset held: outputs at zero before any edge and across edges.
    #1;
    check_both("reset_t0", 5'b00000);
    for (int i = 0; i < 3; i++) step("reset_edge", 1'b1, 5'b11000, 1'b0);

    // Release between edges: nothing changes until an edge.
    clear = 1'b1;
    #1;
    check_both("release", 5'b00000);
    step("zero_rot", 1'b0, 5'b11111, 1'b0);

    // Load and rotate for 15 edges (three full periods).
    step("load_11000", 1'b1, 5'b11000, 1'b0);
    for (int i = 0; i < 15; i++) step("rotate", 1'b0, 5'b00000, 1'b0);
    check_both("period", 5'b11000);

    // Unknown preset ignored while not loading.
    step("x_pre_rot", 1'b0, 'x, 1'b0);

    // Wrap of bit 0 into the MSB.
    step("load_00001", 1'b1, 5'b00001, 1'b0);
    step("wrap", 1'b0, 5'b01010, 1'b0);

    // Fixed points.
    step("load_11111", 1'b1, 5'b11111, 1'b0);
    for (int i = 0; i < 3; i++) step("ones_fixed", 1'b0, 5'b00000, 1'b0);
    step("load_00000", 1'b1, 5'b00000, 1'b0);
    for (int i = 0; i < 3; i++) step("zeros_fixed", 1'b0, 5'b11111, 1'b0);

    // Async clear mid-run at 00110, no edge involved.
    step("load_11000b", 1'b1, 5'b11000, 1'b0);
    step("rot_01100", 1'b0, 5'b00000, 1'b0);
    step("rot_00110", 1'b0, 5'b00000, 1'b0);
    check_both("pre_clear", 5'b00110);
    clear = 1'b0;
    #1;
    model_q = '0;
    check_both("async_clear", 5'b00000);
    step("clear_ign_pre", 1'b1, 5'b10101, 1'b0);
    clear = 1'b1;
    step("after_clear", 1'b1, 5'b10101, 1'b0);
    step("rot_after", 1'b0, 5'b00000, 1'b0);

`ifdef SR_HOLD_EN
    // Hold freezes, release resumes rotation, load beats hold.
    step("hold_load", 1'b1, 5'b11000, 1'b0);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 5'b00000, 1'b1);
    check_both("held", 5'b11000);
    step("hold_release", 1'b0, 5'b00000, 1'b0);
    check_both("released", 5'b01100);
    step("load_over_hold", 1'b1, 5'b10011, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_shift_register_circular_right5

// File: doc/shift_register_circular_right5.md
Name: shift_register_circular_right5

Overview:
- 5-bit parallel-load circular (rotate-right) shift register with true and complemented outputs.
- Used in the lab datapath as a ring-counter/pattern generator, seeded via a synchronous parallel preset.
- Single clock domain; asynchronous active-low clear.

Parameters:
- WIDTH, 5, register width in bits; all vector ports are WIDTH wide. The block is specified and verified at 5.

Ports:
- clockpulse  input  1  clock; state updates on rising edge
- clear  input  1  asynchronous active-low reset; 0 forces the register to all zeros
- preset_enable  input  1  synchronous parallel-load enable, active-high
- preset  input  WIDTH  parallel-load value
- signal_q  output  WIDTH  register contents; bit WIDTH-1 is MSB
- signal_q_  output  WIDTH  bitwise complement of signal_q

Behaviour:
- Reset: clear=0 immediately (no clock needed) sets signal_q=5'b00000 and signal_q_=5'b11111. Outputs are held while clear=0, regardless of clock or preset_enable.
- Clear release: deassertion is asynchronous. The first rising edge with clear=1 performs a normal update.
- Each rising clockpulse edge with clear=1:
  - preset_enable=1: signal_q <= preset (load has priority over rotate).
  - preset_enable=0: rotate right by one bit. q[i] <= q[i+1] for i=0..WIDTH-2, and q[WIDTH-1] <= q[0]. Example: 11000 -> 01100.
- Latency: a load or rotate is visible one edge after sampling. Inputs are sampled only at the rising edge.
- signal_q_ is combinational ~signal_q at all times, including during reset.
- Rotation period is WIDTH clocks; after 5 rotations the value returns to its original pattern.
- All-zeros and all-ones patterns are fixed points under rotation.
- Clear asserted mid-sequence aborts immediately to zero. A pending preset_enable is ignored while clear=0.
- No X propagation from preset when preset_enable=0.

Optional Feature:
- Macro SR_HOLD_EN.
- When defined:
  - Adds input port hold (1 bit, active-high).
  - At a rising edge with clear=1, preset_enable=0 and hold=1, signal_q keeps its value.
  - Priority is clear > preset_enable > hold > rotate.
- When undefined:
  - Port hold is absent.
  - The register rotates on every edge unless loading.

Decomposition:
- Shared package shift_register_pkg: constant SR_WIDTH=5 and the reset value constant SR_RESET_VAL='0.
- One natural sub-module: dff_async_clr, a single-bit D flip-flop with asynchronous active-low clear.
  - The top instantiates WIDTH of them.
  - Each bit's D input is selected by a per-bit next-state mux (preset bit / hold / neighbour bit).

Test Plan:
- Reset: clear=0 with clock toggling, preset_enable=1, preset=11000 -> signal_q=00000 and signal_q_=11111 throughout. Release clear -> values unchanged until the next edge.
- Load: clear=1, preset=11000, preset_enable=1 for one edge -> signal_q=11000, signal_q_=00111.
- Rotate: after the load, 5 further edges with preset_enable=0 -> signal_q sequence 01100, 00110, 00011, 10001, 11000. Continue to 15 total edges to confirm periodicity.
- Wrap/fixed points: load 00001, one edge -> 10000. Load 11111 -> stays 11111. Load 00000 -> stays 00000.
- Async clear mid-run: assert clear=0 between edges while signal_q=00110 -> signal_q=00000 immediately, with no clock edge.
- SR_HOLD_EN build: load 11000, hold=1 for 3 edges -> stays 11000. Release hold -> 01100 on the next edge. preset_enable=1 with hold=1 -> load wins.
